wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles an MDU request may be refused before it is force-granted (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on posedge clk.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port pipeValid, input, 1, pipeline writeback latch holds a register write this cycle.
REQ-005 SHALL have port pipeRd, input, 5, pipeline destination register.
REQ-006 SHALL have port pipeData, input, 32, pipeline write data.
REQ-007 SHALL have port mduValid, input, 1, multi-cycle mul/div unit offers a result.
REQ-008 SHALL have port mduRd, input, 5, MDU destination register.
REQ-009 SHALL have port mduData, input, 32, MDU result.
REQ-010 SHALL have port mduReady, output, 1, MDU result is accepted this cycle.
REQ-011 SHALL have port pipeStall, output, 1, pipeline writeback latch and upstream stages must hold this cycle.
REQ-012 SHALL have port regWrite, output, 1, register file write enable (registered).
REQ-013 SHALL have port rd, output, 5, register file write address (registered).
REQ-014 SHALL have port dataToReg, output, 32, register file write data (registered).

Function
REQ-015 SHALL implement states PIPE_PRI (default) and MDU_FORCE, plus a starvation counter starveCnt of 4 bits.
REQ-016 In PIPE_PRI, mduReady SHALL be mduValid & ~pipeValid, and pipeStall SHALL be 0.
REQ-017 In MDU_FORCE, mduReady SHALL be mduValid, and pipeStall SHALL be pipeValid.
REQ-018 mduReady and pipeStall SHALL be combinational from the current state and inputs, with no added latency.
REQ-019 An MDU transfer SHALL occur only in a cycle where mduValid & mduReady; mduRd/mduData SHALL be held stable by the MDU until that cycle.
REQ-020 A pipeline write SHALL be accepted in any cycle where pipeValid & ~pipeStall.
REQ-021 The accepted write (at most one per cycle) SHALL appear on regWrite/rd/dataToReg exactly one cycle later.
REQ-022 In a cycle with no accepted write, regWrite SHALL be 0 on the next cycle, and rd/dataToReg SHALL hold their previous values.
REQ-023 An accepted write with destination x0 SHALL complete its handshake but SHALL drive regWrite=0, with rd=0 and dataToReg holding its previous value.
REQ-024 starveCnt SHALL increment (saturating at STARVE_LIMIT) each cycle mduValid & ~mduReady, and SHALL clear on any MDU transfer or when mduValid=0.
REQ-025 Transition PIPE_PRI->MDU_FORCE SHALL occur at the clock edge where the next starveCnt value equals STARVE_LIMIT.
REQ-026 MDU_FORCE SHALL last exactly one cycle and then return to PIPE_PRI; if mduValid drops in MDU_FORCE, the FSM SHALL still return to PIPE_PRI with no write.
REQ-027 If a forced MDU write and the stalled pipeline write target the same rd, the MDU write SHALL commit first and the pipeline write SHALL commit one cycle later (program order preserved: pipeline value wins).
REQ-028 mduValid without pipeValid SHALL be granted in the same cycle, with starveCnt staying 0.
REQ-029 pipeStall SHALL never be asserted for two consecutive cycles.

Reset
REQ-030 Asserting reset SHALL immediately (asynchronously) force state=PIPE_PRI, starveCnt=0, regWrite=0, rd=0, dataToReg=0.
REQ-031 While reset is high, mduReady and pipeStall SHALL be 0, and no write SHALL be accepted.
REQ-032 A reset asserted mid-MDU_FORCE SHALL drop the pending forced grant; the MDU SHALL re-present its result after reset.
REQ-033 After reset deasserts, the first edge SHALL behave as PIPE_PRI with starveCnt=0.

Verification
REQ-034 Pipe only: pipeValid=1, pipeRd=5, pipeData=0x1234 for one cycle -> next cycle regWrite=1, rd=5, dataToReg=0x1234; mduReady=0, pipeStall=0 throughout.
REQ-035 MDU only: mduValid=1, mduRd=7, mduData=0xDEADBEEF -> mduReady=1 same cycle; next cycle regWrite=1, rd=7, dataToReg=0xDEADBEEF.
REQ-036 Starvation: pipeValid=1 continuously, mduValid=1 (rd=9) with STARVE_LIMIT=4 -> mduReady=0 for 4 cycles, then mduReady=1 and pipeStall=1 for exactly one cycle; rd=9 write appears, then pipeline writes resume.
REQ-037 x0 write: pipeValid=1, pipeRd=0, pipeData=0xFFFF -> next cycle regWrite=0, rd=0.
REQ-038 Same rd: forced MDU rd=3 data=0xA while stalled pipe rd=3 data=0xB -> rd=3 written with 0xA, then with 0xB the following cycle.
REQ-039 Async reset: assert reset between edges during MDU_FORCE -> regWrite=0, mduReady=0, pipeStall=0 immediately; after release, starveCnt restarts from 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback normally owns the single
// write port, and a waiting MDU result is force-granted after STARVE_LIMIT refusals.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipeValid,
  input  logic [4:0]  pipeRd,
  input  logic [31:0] pipeData,
  input  logic        mduValid,
  input  logic [4:0]  mduRd,
  input  logic [31:0] mduData,
  output logic        mduReady,
  output logic        pipeStall,
  output logic        regWrite,
  output logic [4:0]  rd,
  output logic [31:0] dataToReg
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {PIPE_PRI, MDU_FORCE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;

  logic        mdu_xfer, pipe_acc;

  always_comb begin
    mduReady     = 1'b0;
    pipeStall    = 1'b0;
    state_d      = PIPE_PRI;
    starve_cnt_d = starve_cnt_q;
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    data_d       = data_q;

    if (!reset) begin
      case (state_q)
        PIPE_PRI:  mduReady = mduValid & ~pipeValid;
        MDU_FORCE: begin
          mduReady  = mduValid;
          pipeStall = pipeValid;
        end
        default:   mduReady = 1'b0;
      endcase
    end

    mdu_xfer = mduValid & mduReady;
    pipe_acc = pipeValid & ~pipeStall & ~reset;

    if (!mduValid || mdu_xfer)
      starve_cnt_d = 4'd0;
    else if (starve_cnt_q >= LIMIT)
      starve_cnt_d = LIMIT;
    else
      starve_cnt_d = starve_cnt_q + 4'd1;

    // Force lasts a single cycle; the cleared counter keeps two forces apart.
    if (state_q == PIPE_PRI && starve_cnt_d == LIMIT)
      state_d = MDU_FORCE;

    // The two grants are mutually exclusive, so at most one write per cycle.
    if (mdu_xfer) begin
      rd_d        = mduRd;
      reg_write_d = (mduRd != 5'd0);
      if (mduRd != 5'd0) data_d = mduData;
    end else if (pipe_acc) begin
      rd_d        = pipeRd;
      reg_write_d = (pipeRd != 5'd0);
      if (pipeRd != 5'd0) data_d = pipeData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PIPE_PRI;
      starve_cnt_q <= 4'd0;
      reg_write_q  <= 1'b0;
      rd_q         <= 5'd0;
      data_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      data_q       <= data_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign rd        = rd_q;
  assign dataToReg = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a table of per-cycle vectors with hand-derived
// expectations, registered results checked through a scoreboard queue.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipeValid, mduValid;
  logic [4:0]  pipeRd, mduRd;
  logic [31:0] pipeData, mduData;
  logic        mduReady, pipeStall, regWrite;
  logic [4:0]  rd;
  logic [31:0] dataToReg;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    logic        mr;
    logic        ps;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[31];

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .pipeValid(pipeValid), .pipeRd(pipeRd), .pipeData(pipeData),
    .mduValid(mduValid), .mduRd(mduRd), .mduData(mduData),
    .mduReady(mduReady), .pipeStall(pipeStall),
    .regWrite(regWrite), .rd(rd), .dataToReg(dataToReg)
  );

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pdata,
                              logic mv, logic [4:0] mrd, logic [31:0] mdata,
                              logic mr, logic ps, logic rw, logic [4:0] erd,
                              logic [31:0] edata);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pdata = pdata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.mr = mr; v.ps = ps; v.rw = rw; v.rd = erd; v.data = edata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipeValid = v.pv; pipeRd = v.prd; pipeData = v.pdata;
    mduValid  = v.mv; mduRd  = v.mrd; mduData  = v.mdata;
  endtask

  // Called 1 time unit after a posedge; ends 1 time unit after the next one.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    #1;
    chk({tag, " mduReady"}, 32'(mduReady), 32'(v.mr));
    chk({tag, " pipeStall"}, 32'(pipeStall), 32'(v.ps));
    sb.push_back('{v.rw, v.rd, v.data, tag});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, " regWrite"}, 32'(regWrite), 32'(e.rw));
    chk({e.tag, " rd"}, 32'(rd), 32'(e.rd));
    chk({e.tag, " dataToReg"}, dataToReg, e.data);
  endtask

  initial begin
    //            pv prd    pdata          mv mrd   mdata           mr ps rw rd     data
    vecs[0]  = mk(1, 5'd5,  32'h1234,      0, 5'd0, 32'h0,          0, 0, 1, 5'd5,  32'h1234);
    vecs[1]  = mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,          0, 0, 0, 5'd5,  32'h1234);
    vecs[2]  = mk(0, 5'd0,  32'h0,         1, 5'd7, 32'hDEADBEEF,   1, 0, 1, 5'd7,  32'hDEADBEEF);
    vecs[3]  = mk(1, 5'd0,  32'hFFFF,      0, 5'd0, 32'h0,          0, 0, 0, 5'd0,  32'hDEADBEEF);
    // starvation with STARVE_LIMIT=4
    vecs[4]  = mk(1, 5'd10, 32'hA0,        1, 5'd9, 32'h99,         0, 0, 1, 5'd10, 32'hA0);
    vecs[5]  = mk(1, 5'd11, 32'hA1,        1, 5'd9, 32'h99,         0, 0, 1, 5'd11, 32'hA1);
    vecs[6]  = mk(1, 5'd12, 32'hA2,        1, 5'd9, 32'h99,         0, 0, 1, 5'd12, 32'hA2);
    vecs[7]  = mk(1, 5'd13, 32'hA3,        1, 5'd9, 32'h99,         0, 0, 1, 5'd13, 32'hA3);
    vecs[8]  = mk(1, 5'd14, 32'hA4,        1, 5'd9, 32'h99,         1, 1, 1, 5'd9,  32'h99);
    vecs[9]  = mk(1, 5'd14, 32'hA4,        0, 5'd0, 32'h0,          0, 0, 1, 5'd14, 32'hA4);
    // forced MDU and stalled pipe hit the same rd
    vecs[10] = mk(1, 5'd20, 32'h20,        1, 5'd3, 32'hA,          0, 0, 1, 5'd20, 32'h20);
    vecs[11] = mk(1, 5'd21, 32'h21,        1, 5'd3, 32'hA,          0, 0, 1, 5'd21, 32'h21);
    vecs[12] = mk(1, 5'd22, 32'h22,        1, 5'd3, 32'hA,          0, 0, 1, 5'd22, 32'h22);
    vecs[13] = mk(1, 5'd23, 32'h23,        1, 5'd3, 32'hA,          0, 0, 1, 5'd23, 32'h23);
    vecs[14] = mk(1, 5'd3,  32'hB,         1, 5'd3, 32'hA,          1, 1, 1, 5'd3,  32'hA);
    vecs[15] = mk(1, 5'd3,  32'hB,         0, 5'd0, 32'h0,          0, 0, 1, 5'd3,  32'hB);
    // MDU withdraws during the forced cycle: stall still happens, no write
    vecs[16] = mk(1, 5'd1,  32'h101,       1, 5'd4, 32'h44,         0, 0, 1, 5'd1,  32'h101);
    vecs[17] = mk(1, 5'd1,  32'h102,       1, 5'd4, 32'h44,         0, 0, 1, 5'd1,  32'h102);
    vecs[18] = mk(1, 5'd1,  32'h103,       1, 5'd4, 32'h44,         0, 0, 1, 5'd1,  32'h103);
    vecs[19] = mk(1, 5'd1,  32'h104,       1, 5'd4, 32'h44,         0, 0, 1, 5'd1,  32'h104);
    vecs[20] = mk(1, 5'd2,  32'h200,       0, 5'd0, 32'h0,          0, 1, 0, 5'd1,  32'h104);
    vecs[21] = mk(1, 5'd2,  32'h200,       0, 5'd0, 32'h0,          0, 0, 1, 5'd2,  32'h200);
    // a gap in mduValid restarts the starvation count
    vecs[22] = mk(1, 5'd6,  32'h60,        1, 5'd8, 32'h80,         0, 0, 1, 5'd6,  32'h60);
    vecs[23] = mk(1, 5'd6,  32'h61,        0, 5'd0, 32'h0,          0, 0, 1, 5'd6,  32'h61);
    vecs[24] = mk(1, 5'd6,  32'h62,        1, 5'd8, 32'h80,         0, 0, 1, 5'd6,  32'h62);
    vecs[25] = mk(1, 5'd6,  32'h63,        1, 5'd8, 32'h80,         0, 0, 1, 5'd6,  32'h63);
    vecs[26] = mk(1, 5'd6,  32'h64,        1, 5'd8, 32'h80,         0, 0, 1, 5'd6,  32'h64);
    vecs[27] = mk(1, 5'd6,  32'h65,        1, 5'd8, 32'h80,         0, 0, 1, 5'd6,  32'h65);
    vecs[28] = mk(1, 5'd6,  32'h66,        1, 5'd8, 32'h80,         1, 1, 1, 5'd8,  32'h80);
    vecs[29] = mk(1, 5'd6,  32'h66,        0, 5'd0, 32'h0,          0, 0, 1, 5'd6,  32'h66);
    vecs[30] = mk(0, 5'd0,  32'h0,         0, 5'd0, 32'h0,          0, 0, 0, 5'd6,  32'h66);

    // reset with requests present: nothing granted, outputs cleared
    reset = 1'b1;
    drive(mk(1, 5'd5, 32'h55, 1, 5'd7, 32'h77, 0, 0, 0, 5'd0, 32'h0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset regWrite", 32'(regWrite), 32'd0);
    chk("reset rd", 32'(rd), 32'd0);
    chk("reset dataToReg", dataToReg, 32'd0);
    chk("reset mduReady", 32'(mduReady), 32'd0);
    chk("reset pipeStall", 32'(pipeStall), 32'd0);
    drive(mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0));
    reset = 1'b0;

    for (int i = 0; i < 31; i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // async reset in the middle of a forced cycle
    for (int i = 0; i < 4; i++)
      step(mk(1, 5'd15, 32'h50 + 32'(i), 1, 5'd9, 32'h77, 0, 0, 1, 5'd15, 32'h50 + 32'(i)),
           $sformatf("pre%0d", i));
    drive(mk(1, 5'd15, 32'h55, 1, 5'd9, 32'h77, 0, 0, 0, 5'd0, 32'h0));
    #1;
    chk("force mduReady", 32'(mduReady), 32'd1);
    chk("force pipeStall", 32'(pipeStall), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst regWrite", 32'(regWrite), 32'd0);
    chk("arst rd", 32'(rd), 32'd0);
    chk("arst dataToReg", dataToReg, 32'd0);
    chk("arst mduReady", 32'(mduReady), 32'd0);
    chk("arst pipeStall", 32'(pipeStall), 32'd0);
    @(posedge clk); #1;
    chk("arst hold regWrite", 32'(regWrite), 32'd0);
    chk("arst hold rd", 32'(rd), 32'd0);
    reset = 1'b0;

    // count restarts from zero: four refusals again before the force
    for (int i = 0; i < 4; i++)
      step(mk(1, 5'd15, 32'h60 + 32'(i), 1, 5'd9, 32'h77, 0, 0, 1, 5'd15, 32'h60 + 32'(i)),
           $sformatf("post%0d", i));
    step(mk(1, 5'd15, 32'h64, 1, 5'd9, 32'h77, 1, 1, 1, 5'd9, 32'h77), "postforce");
    step(mk(1, 5'd15, 32'h64, 0, 5'd0, 32'h0, 0, 0, 1, 5'd15, 32'h64), "postresume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
